// File: rtl/pwm_shift_ctrl_if.sv
// Configuration write port for pwm_shift_ctrl: one shadow-register write per cycle.
// The master side drives the strobe, address and data; the PWM block is the slave.
interface pwm_shift_ctrl_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 8
) ();
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [CNT_W-1:0]  wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/pwm_shift_ctrl.sv
// Multi-channel PWM generator feeding an external SIPO shift register.
// Every frame shifts all channels against one counter snapshot, then latches.
module pwm_shift_ctrl #(
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned PERIOD_RST = 100,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned INVERT     = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    pwm_shift_ctrl_if.slave     cfg,
    output logic                sr_data,
    output logic                sr_shift,
    output logic                sr_latch,
    output logic [CHANNELS-1:0] pwm_mirror,
    output logic [CNT_W-1:0]    cnt_out,
    output logic                busy
);

    localparam int unsigned       IDX_W       = $clog2(CHANNELS);
    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(CHANNELS - 1);
    localparam logic [ADDR_W-1:0] PERIOD_ADDR = ADDR_W'(CHANNELS);
    localparam logic              INV         = (INVERT != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    snap_q, snap_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    duty_sh_q [CHANNELS];
    logic [CNT_W-1:0]    duty_sh_d [CHANNELS];
    logic [CNT_W-1:0]    duty_act_q [CHANNELS];
    logic [CNT_W-1:0]    duty_act_d [CHANNELS];
    logic [CNT_W-1:0]    period_sh_q, period_sh_d;
    logic [CNT_W-1:0]    period_act_q, period_act_d;
    logic [CHANNELS-1:0] pattern_q, pattern_d;
    logic [CHANNELS-1:0] mirror_q, mirror_d;
    logic                sr_data_q, sr_data_d;
    logic                sr_shift_q, sr_shift_d;
    logic                sr_latch_q, sr_latch_d;
    logic                busy_q, busy_d;

    logic                emit;
    logic [IDX_W-1:0]    emit_idx;
    logic [CNT_W-1:0]    emit_cnt;
    logic                emit_bit;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        cnt_d        = cnt_q;
        duty_sh_d    = duty_sh_q;
        duty_act_d   = duty_act_q;
        period_sh_d  = period_sh_q;
        period_act_d = period_act_q;
        pattern_d    = pattern_q;
        mirror_d     = mirror_q;
        sr_data_d    = 1'b0;
        sr_shift_d   = 1'b0;
        sr_latch_d   = 1'b0;
        emit         = 1'b0;
        emit_idx     = IDX_LAST;
        emit_cnt     = snap_q;
        emit_bit     = 1'b0;

        if (cfg.wr_en) begin
            if (cfg.wr_addr == PERIOD_ADDR) begin
                period_sh_d = cfg.wr_data;
            end
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                if (cfg.wr_addr == ADDR_W'(ch)) begin
                    duty_sh_d[ch] = cfg.wr_data;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d  = ST_SHIFT;
                    idx_d    = IDX_LAST;
                    snap_d   = cnt_q;
                    emit     = 1'b1;
                    emit_idx = IDX_LAST;
                    emit_cnt = cnt_q;
                end
            end
            ST_SHIFT: begin
                if (idx_q == '0) begin
                    state_d    = ST_LATCH;
                    sr_latch_d = 1'b1;
                end else begin
                    idx_d    = idx_q - 1'b1;
                    emit     = 1'b1;
                    emit_idx = idx_q - 1'b1;
                    emit_cnt = snap_q;
                end
            end
            ST_LATCH: begin
                mirror_d = pattern_q;
                // Shadow copy reads the _q values, so a write on the wrap edge waits for the next wrap.
                if (cnt_q >= period_act_q) begin
                    cnt_d        = '0;
                    duty_act_d   = duty_sh_q;
                    period_act_d = period_sh_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (enable) begin
                    state_d  = ST_SHIFT;
                    idx_d    = IDX_LAST;
                    snap_d   = cnt_d;
                    emit     = 1'b1;
                    emit_idx = IDX_LAST;
                    emit_cnt = cnt_d;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so the bit for the upcoming shift cycle is computed one edge early.
        if (emit) begin
            emit_bit            = (emit_cnt < duty_act_d[emit_idx]) ^ INV;
            sr_shift_d          = 1'b1;
            sr_data_d           = emit_bit;
            pattern_d[emit_idx] = emit_bit;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= IDX_LAST;
            snap_q       <= '0;
            cnt_q        <= '0;
            duty_sh_q    <= '{default: '0};
            duty_act_q   <= '{default: '0};
            period_sh_q  <= CNT_W'(PERIOD_RST);
            period_act_q <= CNT_W'(PERIOD_RST);
            pattern_q    <= '0;
            mirror_q     <= '0;
            sr_data_q    <= 1'b0;
            sr_shift_q   <= 1'b0;
            sr_latch_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            cnt_q        <= cnt_d;
            duty_sh_q    <= duty_sh_d;
            duty_act_q   <= duty_act_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            pattern_q    <= pattern_d;
            mirror_q     <= mirror_d;
            sr_data_q    <= sr_data_d;
            sr_shift_q   <= sr_shift_d;
            sr_latch_q   <= sr_latch_d;
            busy_q       <= busy_d;
        end
    end

    assign sr_data    = sr_data_q;
    assign sr_shift   = sr_shift_q;
    assign sr_latch   = sr_latch_q;
    assign pwm_mirror = mirror_q;
    assign cnt_out    = cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pwm_shift_ctrl.sv
// Directed bench for pwm_shift_ctrl: a normal and an INVERT=1 instance share
// clock, reset, enable and the config port; each frame is captured and checked.
module tb_pwm_shift_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;

    always #5 clk = ~clk;

    pwm_shift_ctrl_if #(.ADDR_W(4), .CNT_W(8)) cfg_if ();

    logic       n_data, n_shift, n_latch, n_busy;
    logic [7:0] n_mirror, n_cnt;
    logic       i_data, i_shift, i_latch, i_busy;
    logic [7:0] i_mirror, i_cnt;

    pwm_shift_ctrl #(.CHANNELS(8), .CNT_W(8), .PERIOD_RST(100), .ADDR_W(4), .INVERT(0)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .cfg(cfg_if),
        .sr_data(n_data), .sr_shift(n_shift), .sr_latch(n_latch),
        .pwm_mirror(n_mirror), .cnt_out(n_cnt), .busy(n_busy)
    );

    pwm_shift_ctrl #(.CHANNELS(8), .CNT_W(8), .PERIOD_RST(100), .ADDR_W(4), .INVERT(1)) dut_inv (
        .clk(clk), .reset_n(reset_n), .enable(enable), .cfg(cfg_if),
        .sr_data(i_data), .sr_shift(i_shift), .sr_latch(i_latch),
        .pwm_mirror(i_mirror), .cnt_out(i_cnt), .busy(i_busy)
    );

    int checks = 0;
    int failures = 0;

    // Active duty/period as the bench expects them to be after each wrap.
    logic [7:0] m_duty [8];
    logic [7:0] m_period;
    logic [7:0] prev_exp;

    logic [7:0] fr_bits, fr_inv, fr_mirror, fr_mirror_i, fr_cnt;
    int         fr_shifts;
    logic       fr_latch, fr_busy, fr_cnt_ok;

    function automatic logic [7:0] exp_bits(input logic [7:0] c);
        logic [7:0] r;
        for (int ch = 0; ch < 8; ch++) r[ch] = (c < m_duty[ch]);
        return r;
    endfunction

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        cfg_if.wr_en   = 1'b1;
        cfg_if.wr_addr = a;
        cfg_if.wr_data = d;
        @(negedge clk);
        cfg_if.wr_en   = 1'b0;
    endtask

    task automatic wait_latch(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (n_latch === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called at the negedge of a latch cycle; ends at the negedge of the next latch cycle.
    task automatic next_frame();
        fr_shifts = 0;
        fr_bits   = '0;
        fr_inv    = '0;
        fr_busy   = 1'b1;
        fr_cnt_ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (n_shift === 1'b1 && i_shift === 1'b1) fr_shifts++;
            fr_bits[3'(7 - k)] = n_data;
            fr_inv[3'(7 - k)]  = i_data;
            if (n_busy !== 1'b1) fr_busy = 1'b0;
            if (k == 0) begin
                fr_cnt      = n_cnt;
                fr_mirror   = n_mirror;
                fr_mirror_i = i_mirror;
            end else if (n_cnt !== fr_cnt) begin
                fr_cnt_ok = 1'b0;
            end
        end
        @(negedge clk);
        fr_latch = (n_latch === 1'b1) && (n_shift === 1'b0) && (i_latch === 1'b1) && (n_busy === 1'b1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        cfg_if.wr_en   = 1'b0;
        cfg_if.wr_addr = '0;
        cfg_if.wr_data = '0;
        for (int ch = 0; ch < 8; ch++) m_duty[ch] = 8'd0;
        m_period = 8'd100;
        prev_exp = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({n_data, n_shift, n_latch, n_busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes: got %b expected 0000", {n_data, n_shift, n_latch, n_busy});
        end
        checks++;
        if (n_mirror !== 8'h00 || n_cnt !== 8'h00) begin
            failures++;
            $display("FAIL reset_mirror_cnt: got mirror=%h cnt=%0d expected 00/0", n_mirror, n_cnt);
        end
        checks++;
        if (i_data !== 1'b0 || i_mirror !== 8'h00) begin
            failures++;
            $display("FAIL reset_inv_zero: got data=%b mirror=%h expected 0/00", i_data, i_mirror);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (n_shift !== 1'b0 || n_busy !== 1'b0 || n_cnt !== 8'd0) begin
            failures++;
            $display("FAIL idle_hold: got shift=%b busy=%b cnt=%0d expected 0/0/0", n_shift, n_busy, n_cnt);
        end
    endtask

    task automatic test_default_frames();
        bit ok;
        int n;
        logic [7:0] c;
        enable = 1'b1;
        wait_latch(ok, n);
        checks++;
        if (!ok || n != 9) begin
            failures++;
            $display("FAIL first_frame_len: got ok=%0d cycles=%0d expected 1/9", ok, n);
        end
        for (int f = 0; f <= 100; f++) begin
            c = 8'((f + 1) % 101);
            next_frame();
            checks++;
            if (fr_shifts != 8 || !fr_latch || !fr_busy || !fr_cnt_ok) begin
                failures++;
                $display("FAIL default_shape: got shifts=%0d latch=%b busy=%b cnt_stable=%b expected 8/1/1/1", fr_shifts, fr_latch, fr_busy, fr_cnt_ok);
            end
            checks++;
            if (fr_cnt !== c) begin
                failures++;
                $display("FAIL default_cnt: got %0d expected %0d", fr_cnt, c);
            end
            checks++;
            if (fr_bits !== 8'h00 || fr_inv !== 8'hFF) begin
                failures++;
                $display("FAIL default_data: got %h/%h expected 00/ff", fr_bits, fr_inv);
            end
        end
        prev_exp = 8'h00;
    endtask

    task automatic test_shadow_writes();
        bit ok;
        int n;
        logic [7:0] e;
        int hi7, hi0;
        logic [7:0] seq [11];
        wr(4'd7, 8'd25);
        wr(4'd0, 8'd50);
        wr(4'd8, 8'd9);
        wr(4'd9, 8'd200);
        wr(4'd15, 8'd7);
        wait_latch(ok, n);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL shadow_sync: got timeout expected latch");
        end
        for (int c = 2; c <= 100; c++) begin
            next_frame();
            e = exp_bits(8'(c));
            checks++;
            if (fr_cnt !== 8'(c) || fr_bits !== e || fr_inv !== ~e) begin
                failures++;
                $display("FAIL shadow_hold: got cnt=%0d bits=%h inv=%h expected %0d/%h/%h", fr_cnt, fr_bits, fr_inv, c, e, ~e);
            end
            prev_exp = e;
        end
        m_duty[7] = 8'd25;
        m_duty[0] = 8'd50;
        m_period  = 8'd9;
        seq = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd0};
        for (int f = 0; f < 11; f++) begin
            next_frame();
            checks++;
            if (fr_cnt !== seq[f] || fr_bits !== 8'h81 || fr_inv !== 8'h7E) begin
                failures++;
                $display("FAIL period9: got cnt=%0d bits=%h inv=%h expected %0d/81/7e", fr_cnt, fr_bits, fr_inv, seq[f]);
            end
            checks++;
            if (fr_mirror !== prev_exp || fr_mirror_i !== ~prev_exp) begin
                failures++;
                $display("FAIL period9_mirror: got %h/%h expected %h/%h", fr_mirror, fr_mirror_i, prev_exp, ~prev_exp);
            end
            prev_exp = 8'h81;
        end
        wr(4'd8, 8'd99);
        wait_latch(ok, n);
        for (int c = 2; c <= 9; c++) next_frame();
        checks++;
        if (!ok || fr_cnt !== 8'd9) begin
            failures++;
            $display("FAIL period99_sync: got ok=%0d cnt=%0d expected 1/9", ok, fr_cnt);
        end
        m_period = 8'd99;
        hi7 = 0;
        hi0 = 0;
        for (int c = 0; c <= 99; c++) begin
            next_frame();
            if (fr_bits[7] === 1'b1) hi7++;
            if (fr_bits[0] === 1'b1) hi0++;
            checks++;
            if (fr_cnt !== 8'(c)) begin
                failures++;
                $display("FAIL period99_cnt: got %0d expected %0d", fr_cnt, c);
            end
        end
        checks++;
        if (hi7 != 25 || hi0 != 50) begin
            failures++;
            $display("FAIL duty_count: got ch7=%0d ch0=%0d expected 25/50", hi7, hi0);
        end
        next_frame();
        checks++;
        if (fr_cnt !== 8'd0) begin
            failures++;
            $display("FAIL period99_wrap: got %0d expected 0", fr_cnt);
        end
        prev_exp = exp_bits(8'd0);
    endtask

    task automatic test_duty_extremes();
        bit ok;
        int n;
        logic [7:0] e;
        wr(4'd3, 8'd0);
        wr(4'd4, 8'd255);
        wr(4'd8, 8'd100);
        wait_latch(ok, n);
        for (int c = 2; c <= 99; c++) begin
            next_frame();
            e = exp_bits(8'(c));
            checks++;
            if (fr_cnt !== 8'(c) || fr_bits !== e) begin
                failures++;
                $display("FAIL extremes_hold: got cnt=%0d bits=%h expected %0d/%h", fr_cnt, fr_bits, c, e);
            end
            prev_exp = e;
        end
        m_duty[4] = 8'd255;
        m_period  = 8'd100;
        for (int c = 0; c <= 100; c++) begin
            next_frame();
            e = exp_bits(8'(c));
            checks++;
            if (fr_bits[4] !== 1'b1 || fr_bits[3] !== 1'b0 || fr_inv[4] !== 1'b0 || fr_inv[3] !== 1'b1) begin
                failures++;
                $display("FAIL extremes_ch34: got bits=%h inv=%h expected ch4=1 ch3=0", fr_bits, fr_inv);
            end
            checks++;
            if (fr_cnt !== 8'(c) || fr_bits !== e || fr_mirror !== prev_exp || fr_mirror_i !== ~prev_exp) begin
                failures++;
                $display("FAIL extremes_frame: got cnt=%0d bits=%h mirror=%h expected %0d/%h/%h", fr_cnt, fr_bits, fr_mirror, c, e, prev_exp);
            end
            prev_exp = e;
        end
        // Write lands on the wrap edge itself; the old duty must still be active.
        cfg_if.wr_en   = 1'b1;
        cfg_if.wr_addr = 4'd0;
        cfg_if.wr_data = 8'd0;
        next_frame();
        cfg_if.wr_en   = 1'b0;
        checks++;
        if (fr_cnt !== 8'd0 || fr_bits !== 8'h91 || fr_mirror[4] !== 1'b1 || fr_mirror[3] !== 1'b0) begin
            failures++;
            $display("FAIL write_at_wrap: got cnt=%0d bits=%h mirror=%h expected 0/91/1x0xxxx", fr_cnt, fr_bits, fr_mirror);
        end
        prev_exp = 8'h91;
    endtask

    task automatic test_bit_order();
        bit ok;
        int n;
        logic [7:0] seq [5];
        wr(4'd7, 8'd255);
        wr(4'd4, 8'd0);
        wr(4'd8, 8'd3);
        wait_latch(ok, n);
        for (int c = 2; c <= 100; c++) begin
            next_frame();
            prev_exp = exp_bits(8'(c));
        end
        checks++;
        if (!ok || fr_cnt !== 8'd100 || fr_bits !== 8'h10) begin
            failures++;
            $display("FAIL bitorder_pre: got cnt=%0d bits=%h expected 100/10", fr_cnt, fr_bits);
        end
        for (int ch = 0; ch < 8; ch++) m_duty[ch] = 8'd0;
        m_duty[7] = 8'd255;
        m_period  = 8'd3;
        seq = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
        for (int f = 0; f < 5; f++) begin
            next_frame();
            checks++;
            if (fr_bits !== 8'h80 || fr_inv !== 8'h7F || fr_cnt !== seq[f]) begin
                failures++;
                $display("FAIL bit_order: got bits=%h inv=%h cnt=%0d expected 80/7f/%0d", fr_bits, fr_inv, fr_cnt, seq[f]);
            end
            checks++;
            if (fr_mirror !== prev_exp) begin
                failures++;
                $display("FAIL bitorder_mirror: got %h expected %h", fr_mirror, prev_exp);
            end
            prev_exp = 8'h80;
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int n;
        int sh;
        bit frozen;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        checks++;
        if (n_cnt !== 8'd1 || n_shift !== 1'b1) begin
            failures++;
            $display("FAIL drop_snap: got cnt=%0d shift=%b expected 1/1", n_cnt, n_shift);
        end
        sh = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (n_shift === 1'b1) sh++;
        end
        @(negedge clk);
        checks++;
        if (sh != 5 || n_latch !== 1'b1) begin
            failures++;
            $display("FAIL drop_finish: got shifts=%0d latch=%b expected 5/1", sh, n_latch);
        end
        @(negedge clk);
        checks++;
        if (n_shift !== 1'b0 || n_latch !== 1'b0 || n_busy !== 1'b0 || n_mirror !== 8'h80) begin
            failures++;
            $display("FAIL drop_idle: got shift=%b latch=%b busy=%b mirror=%h expected 0/0/0/80", n_shift, n_latch, n_busy, n_mirror);
        end
        frozen = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (n_cnt !== 8'd2 || n_shift !== 1'b0) frozen = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!frozen) begin
            failures++;
            $display("FAIL drop_frozen: got cnt=%0d expected 2 held", n_cnt);
        end
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (n_shift !== 1'b1 || n_cnt !== 8'd2 || n_data !== 1'b1) begin
            failures++;
            $display("FAIL resume: got shift=%b cnt=%0d data=%b expected 1/2/1", n_shift, n_cnt, n_data);
        end
        wait_latch(ok, n);
        checks++;
        if (!ok || n != 8) begin
            failures++;
            $display("FAIL resume_len: got ok=%0d cycles=%0d expected 1/8", ok, n);
        end
        next_frame();
        checks++;
        if (fr_cnt !== 8'd3 || fr_bits !== 8'h80) begin
            failures++;
            $display("FAIL resume_next: got cnt=%0d bits=%h expected 3/80", fr_cnt, fr_bits);
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int n;
        bit no_latch;
        next_frame();
        repeat (5) @(negedge clk);
        checks++;
        if (n_cnt !== 8'd1 || n_shift !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: got cnt=%0d shift=%b expected 1/1", n_cnt, n_shift);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({n_data, n_shift, n_latch, n_busy} !== 4'b0000 || n_mirror !== 8'h00 || n_cnt !== 8'd0 || i_data !== 1'b0 || i_mirror !== 8'h00) begin
            failures++;
            $display("FAIL midframe_reset: got %b mirror=%h cnt=%0d inv=%b/%h expected all 0", {n_data, n_shift, n_latch, n_busy}, n_mirror, n_cnt, i_data, i_mirror);
        end
        no_latch = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (n_latch !== 1'b0 || i_latch !== 1'b0) no_latch = 1'b0;
        end
        checks++;
        if (!no_latch) begin
            failures++;
            $display("FAIL reset_no_latch: got latch pulse expected none");
        end
        for (int ch = 0; ch < 8; ch++) m_duty[ch] = 8'd0;
        m_period = 8'd100;
        reset_n = 1'b1;
        wait_latch(ok, n);
        checks++;
        if (!ok || n != 9) begin
            failures++;
            $display("FAIL post_reset_len: got ok=%0d cycles=%0d expected 1/9", ok, n);
        end
        next_frame();
        checks++;
        if (fr_cnt !== 8'd1 || fr_bits !== 8'h00 || fr_inv !== 8'hFF) begin
            failures++;
            $display("FAIL duty_cleared: got cnt=%0d bits=%h inv=%h expected 1/00/ff", fr_cnt, fr_bits, fr_inv);
        end
        checks++;
        if (fr_mirror !== 8'h00 || fr_mirror_i !== 8'hFF) begin
            failures++;
            $display("FAIL post_reset_mirror: got %h/%h expected 00/ff", fr_mirror, fr_mirror_i);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_default_frames();
        test_shadow_writes();
        test_duty_extremes();
        test_bit_order();
        test_enable_drop();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
